// File: rtl/multiplier_datapath.sv
// Shift-add datapath for an 8x8 signed multiplier.
// A sequencing controller drives one command per cycle. X:A:B forms a
// 17-bit shift chain: A and B end up holding the 16-bit product, and X
// holds the sign extension of A.
module multiplier_datapath (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Clr_Ld,
    input  logic       Shift_XAB,
    input  logic       Add,
    input  logic       Sub,
    input  logic [7:0] S,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       X,
    output logic       M
);

    logic       x_q, x_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [8:0] addSum;
    logic [8:0] subSum;

    // 9-bit sign-extended add/subtract of the live switch operand. Bit 8 is
    // the true sign of the result and feeds X.
    always_comb begin
        addSum = {a_q[7], a_q} + {S[7], S};
        subSum = {a_q[7], a_q} + ~{S[7], S} + 9'd1;
    end

    // Next-state selection with fixed priority load > sub > add > shift,
    // so exactly one operation takes effect in any cycle.
    always_comb begin
        x_d = x_q;
        a_d = a_q;
        b_d = b_q;
        if (Clr_Ld) begin
            x_d = 1'b0;
            a_d = 8'h00;
            b_d = S;
        end else if (Sub) begin
            x_d = subSum[8];
            a_d = subSum[7:0];
        end else if (Add) begin
            x_d = addSum[8];
            a_d = addSum[7:0];
        end else if (Shift_XAB) begin
            a_d = {x_q, a_q[7:1]};
            b_d = {a_q[0], b_q[7:1]};
        end
    end

    // Register bank. Reset clears everything immediately so that an
    // interrupted multiply leaves no partial product behind.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_q <= 1'b0;
            a_q <= 8'h00;
            b_q <= 8'h00;
        end else begin
            x_q <= x_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // The controller looks at B[0] directly, so the next multiplier bit is
    // visible as soon as a shift or load commits.
    always_comb begin
        Aval = a_q;
        Bval = b_q;
        X    = x_q;
        M    = b_q[0];
    end

endmodule

// File: doc/multiplier_datapath.md
MULTIPLIER_DATAPATH -- requirements
Module: multiplier_datapath

Interface
REQ-001 SHALL have port Clk, input, 1, rising-edge system clock.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port Clr_Ld, input, 1: clear X and A, and load B from S.
REQ-004 SHALL have port Shift_XAB, input, 1: arithmetic right shift of X:A:B.
REQ-005 SHALL have port Add, input, 1: {X,A} takes A + S.
REQ-006 SHALL have port Sub, input, 1: {X,A} takes A - S.
REQ-007 SHALL have port S, input, 8: switch operand; multiplicand during a run, multiplier at load.
REQ-008 SHALL have port Aval, output, 8: A register contents (upper product byte).
REQ-009 SHALL have port Bval, output, 8: B register contents (lower product byte, multiplier).
REQ-010 SHALL have port X, output, 1: sign-extension flip-flop.
REQ-011 SHALL have port M, output, 1: current B[0], consumed by the sequencing controller.

Function
REQ-012 SHALL hold three registers: X (1 bit), A (8 bits), B (8 bits); all update only on rising Clk.
REQ-013 SHALL drive Aval, Bval and X directly from the registers, and M combinationally as B[0].
REQ-014 SHALL give command priority Clr_Ld > Sub > Add > Shift_XAB; exactly one operation executes per cycle.
REQ-015 Clr_Ld: SHALL set A to 0x00, X to 0 and B to S.
REQ-016 Add: SHALL compute a 9-bit sum = {A[7],A} + {S[7],S}; SHALL set X to sum[8] and A to sum[7:0]; B unchanged.
REQ-017 Sub: SHALL compute a 9-bit sum = {A[7],A} + ~{S[7],S} + 1; SHALL set X to sum[8] and A to sum[7:0]; B unchanged.
REQ-018 Add/Sub overflow SHALL NOT be flagged; the 9-bit result is authoritative and wraps mod 512.
REQ-019 Shift_XAB: SHALL leave X unchanged; A SHALL take {X, A[7:1]}; B SHALL take {A[0], B[7:1]}.
REQ-020 With no command asserted, X, A and B SHALL hold their values.
REQ-021 Add and Sub asserted together: SHALL perform Sub only.
REQ-022 Clr_Ld together with any other command: SHALL perform load only.
REQ-023 S SHALL be sampled live at the clock edge; no internal copy of S is kept.
REQ-024 M SHALL reflect a new B[0] in the same cycle a shift or load commits, so the controller sees the next bit with zero added latency.
REQ-025 An 8x8 signed multiply (7 Add/Shift pairs, then Sub/Shift, controller-driven, S stable) SHALL leave the 16-bit two's-complement product in A:B, with X equal to the product sign.

Reset
REQ-026 Reset high SHALL immediately (asynchronously) force X=0, A=0x00, B=0x00, hence M=0.
REQ-027 Reset asserted mid-multiply SHALL abandon the operation; registers SHALL stay zero until the first edge after deassertion with a command.
REQ-028 Reset SHALL override all commands asserted in the same cycle.

Verification
REQ-029 Load: Clr_Ld=1, S=0xFD -> next edge A=0x00, X=0, B=0xFD, M=1.
REQ-030 Add sign-extension: A=0x00, X=0, S=0xFF, Add=1 -> X=1, A=0xFF; then Sub=1, A=0x00, S=0x01 -> X=1, A=0xFF.
REQ-031 Shift: X=1, A=0x80, B=0x01, Shift_XAB=1 -> X=1, A=0xC0, B=0x00, M=0.
REQ-032 Full run: B loaded 0xFD (-3), S=0x07, standard 16-cycle command sequence -> A=0xFF, B=0xEB (-21), X=1.
REQ-033 Corner: B=0x80, S=0x80 (-128 x -128), full sequence -> A=0x40, B=0x00, X=0; also Add+Sub+Shift asserted together -> only Sub effect.
REQ-034 Reset pulse between cycle 5 and cycle 6 of a run -> all outputs 0 asynchronously; no command -> they remain 0.
